// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Occupancy counter width is sized for the longest legal mult/div latency.
package pipeline_hazard_controller_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULDIV_LATENCY_MAX = 16;

    // Counter holds at most MULDIV_LATENCY-1, so clog2 of the maximum latency suffices.
    function automatic int cnt_width(input int max_latency);
        return (max_latency <= 2) ? 1 : $clog2(max_latency);
    endfunction

    localparam int CNT_W = cnt_width(MULDIV_LATENCY_MAX);

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX/MEM observation signals in, pipeline enables/flushes out.
// master = datapath side, slave = controller side.
interface pipeline_hazard_controller_if #(
    parameter int STALL_CNT_W = 32
);
    logic [4:0]             IDRs;
    logic [4:0]             IDRt;
    logic                   IDUsesRs;
    logic                   IDUsesRt;
    logic                   IDMulDiv;
    logic                   EXMemRead;
    logic [4:0]             EXDestReg;
    logic                   BranchTaken;

    logic                   PCWrite;
    logic                   IFIDWrite;
    logic                   IDEXWrite;
    logic                   IDEXBubble;
    logic                   EXMEMBubble;
    logic                   IFIDFlush;
    logic                   IDEXFlush;
    logic                   EXMEMFlush;
    logic                   MulDivBusy;
    logic [STALL_CNT_W-1:0] StallCycles;

    modport master (
        output IDRs, IDRt, IDUsesRs, IDUsesRt, IDMulDiv, EXMemRead, EXDestReg, BranchTaken,
        input  PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble,
               IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy, StallCycles
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRs, IDUsesRt, IDMulDiv, EXMemRead, EXDestReg, BranchTaken,
        output PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble,
               IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy, StallCycles
    );

endinterface

// File: rtl/pipeline_hazard_controller_muldiv_occupancy_counter.sv
// RUN/MULDIV state bit plus down-counter tracking how long a mult/div still holds EX.
// State updates on the clock edge; abort (branch flush) returns to RUN immediately.
module pipeline_hazard_controller_muldiv_occupancy_counter
    import pipeline_hazard_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             abort,
    output logic             busy,
    output logic             last
);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    // A zero load value means no stall cycles are owed, so stay in RUN.
                    if (load && (load_val != '0)) begin
                        state_nxt = MULDIV;
                        cnt_nxt   = load_val;
                    end
                end
                MULDIV: begin
                    if (dec) begin
                        if (cnt != '0) begin
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                        if (cnt <= CNT_W'(1)) begin
                            state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy = (state == MULDIV);
    assign last = (state == MULDIV) && (cnt == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, mult/div EX occupancy.
// Latency: all controls combinational from registered state + current inputs; no backpressure.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                          Clk,
    input  logic                          Rst,
    pipeline_hazard_controller_if.slave   hz
);

    localparam logic             MD_MULTI    = (MULDIV_LATENCY > 1);
    localparam logic [CNT_W-1:0] MD_LOAD_VAL = CNT_W'(MULDIV_LATENCY - 1);

    logic lu;
    logic flush;
    logic md_busy;
    logic md_last;
    logic md_load;
    logic md_dec;

    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic idex_bubble;
    logic exmem_bubble;
    logic flush_all;
    logic muldiv_busy;

    logic [STALL_CNT_W-1:0] stall_cnt;

    assign flush = hz.BranchTaken;

    // Load-use only matters in RUN; in MULDIV the ID instruction is frozen anyway.
    assign lu = !md_busy && hz.EXMemRead && (hz.EXDestReg != REG_ZERO) &&
                ((hz.IDUsesRs && (hz.IDRs == hz.EXDestReg)) ||
                 (hz.IDUsesRt && (hz.IDRt == hz.EXDestReg)));

    assign md_load = !md_busy && !flush && !lu && hz.IDMulDiv && MD_MULTI;
    assign md_dec  = md_busy && !flush;

    pipeline_hazard_controller_muldiv_occupancy_counter u_occ (
        .clk      (Clk),
        .rst      (Rst),
        .load     (md_load),
        .load_val (MD_LOAD_VAL),
        .dec      (md_dec),
        .abort    (flush),
        .busy     (md_busy),
        .last     (md_last)
    );

    // Priority: flush > mult/div hold > load-use > normal flow.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        flush_all    = 1'b0;
        muldiv_busy  = 1'b0;
        if (flush) begin
            flush_all = 1'b1;
        end else if (md_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            muldiv_busy  = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign hz.PCWrite     = pc_write;
    assign hz.IFIDWrite   = ifid_write;
    assign hz.IDEXWrite   = idex_write;
    assign hz.IDEXBubble  = idex_bubble;
    assign hz.EXMEMBubble = exmem_bubble;
    assign hz.IFIDFlush   = flush_all;
    assign hz.IDEXFlush   = flush_all;
    assign hz.EXMEMFlush  = flush_all;
    assign hz.MulDivBusy  = muldiv_busy;
    assign hz.StallCycles = stall_cnt;

    // The last-cycle flag can only ever be raised while the occupancy state is MULDIV.
    a_last_implies_busy: assert property (@(posedge Clk) disable iff (Rst) md_last |-> md_busy);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench: each issued cycle pushes its hand-computed expected outputs;
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.STALL_CNT_W(4)) hz_if ();

    pipeline_hazard_controller #(
        .MULDIV_LATENCY (4),
        .STALL_CNT_W    (4)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .hz  (hz_if.slave)
    );

    // {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble, IFIDFlush, IDEXFlush, EXMEMFlush, MulDivBusy}
    localparam logic [8:0] NORM = 9'b1_1_1_0_0_0_0_0_0;
    localparam logic [8:0] LUST = 9'b0_0_1_1_0_0_0_0_0;
    localparam logic [8:0] MDST = 9'b0_0_0_0_1_0_0_0_1;
    localparam logic [8:0] FLSH = 9'b1_1_1_0_0_1_1_1_0;

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [3:0]  sc_exp;
    logic [12:0] obs;

    assign obs = {hz_if.PCWrite, hz_if.IFIDWrite, hz_if.IDEXWrite, hz_if.IDEXBubble,
                  hz_if.EXMEMBubble, hz_if.IFIDFlush, hz_if.IDEXFlush, hz_if.EXMEMFlush,
                  hz_if.MulDivBusy, hz_if.StallCycles};

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                fails++;
                $display("FAIL %s: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                         e.name, obs[12:4], obs[3:0], e.v[12:4], e.v[3:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic md, input logic mr,
                        input logic [4:0] dest, input logic br,
                        input logic [8:0] ctl, input string name);
        exp_t e;
        rst               = r;
        hz_if.IDRs        = rs;
        hz_if.IDRt        = rt;
        hz_if.IDUsesRs    = urs;
        hz_if.IDUsesRt    = urt;
        hz_if.IDMulDiv    = md;
        hz_if.EXMemRead   = mr;
        hz_if.EXDestReg   = dest;
        hz_if.BranchTaken = br;
        e.name = name;
        e.v    = {ctl, sc_exp};
        sb.push_back(e);
        if (r) begin
            sc_exp = 4'd0;
        end else if (!ctl[8] && (sc_exp != 4'hF)) begin
            sc_exp = sc_exp + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [8:0] ctl, input string name);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ctl, name);
    endtask

    task automatic md_issue(input string name);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, NORM, name);
    endtask

    task automatic lu_hit(input logic [8:0] ctl, input string name);
        step(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, ctl, name);
    endtask

    initial begin
        rst               = 1'b1;
        hz_if.IDRs        = '0;
        hz_if.IDRt        = '0;
        hz_if.IDUsesRs    = 1'b0;
        hz_if.IDUsesRt    = 1'b0;
        hz_if.IDMulDiv    = 1'b0;
        hz_if.EXMemRead   = 1'b0;
        hz_if.EXDestReg   = '0;
        hz_if.BranchTaken = 1'b0;
        sc_exp            = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        idle(NORM, "reset_state");

        // Load-use: stalls one cycle, then EX holds the bubble.
        lu_hit(LUST, "lu_stall");
        step(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NORM, "lu_release");
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, NORM, "lu_r0");
        step(1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, LUST, "lu_rt");
        step(1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, NORM, "lu_unused");

        // Mult/div: one RUN cycle then three held cycles.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NORM, "pre_md_reset");
        md_issue("md_enter");
        idle(MDST, "md_busy1");
        lu_hit(MDST, "md_ignores_lu");
        idle(MDST, "md_busy3");
        idle(NORM, "md_done");

        // Branch aborts an in-flight mult/div on its second held cycle.
        md_issue("abort_enter");
        idle(MDST, "abort_busy1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, FLSH, "abort_flush");
        idle(NORM, "abort_after");

        // Branch together with load-use and mult/div: flush only.
        step(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, FLSH, "collide_flush");
        idle(NORM, "collide_after");

        // Branch on the final held cycle.
        md_issue("last_enter");
        idle(MDST, "last_busy1");
        idle(MDST, "last_busy2");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, FLSH, "last_flush");
        idle(NORM, "last_after");

        // Reset held two cycles while mid-occupancy.
        md_issue("rst_enter");
        idle(MDST, "rst_busy1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, MDST, "rst_cycle1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NORM, "rst_cycle2");
        idle(NORM, "rst_release");

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++) begin
            lu_hit(LUST, "sat_lu");
            idle(NORM, "sat_rel");
        end
        lu_hit(LUST, "sat_hold_lu");
        idle(NORM, "sat_hold");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
